yavar_param_counter: RTL and testbench
======================================

// Module: yavar_param_counter
// PURPOSE
//   Parametrised up/down counter, successor to the fixed 4-bit tile counter.
//   Adds programmable width, runtime limit (modulus), wrap/saturate mode,
//   synchronous load, an enable prescaler and a registered terminal-count pulse.
//   Sits behind the tile top-level; count drives uo_out, controls come from ui_in/uio_in.
// PARAMETERS
//   WIDTH       8   counter width in bits (>=2)
//   PRESCALE_W  4   width of prescaler divide field div
//   RESET_VAL   0   count value after reset (must fit in WIDTH)
// PORTS
//   clk       in   1            rising-edge clock
//   rst       in   1            reset, asynchronous, active-high
//   en        in   1            count enable (gates prescaler and stepping)
//   up_dn     in   1            1 = count up, 0 = count down
//   sat_mode  in   1            1 = saturate at boundary, 0 = wrap
//   load      in   1            synchronous load strobe
//   load_val  in   WIDTH        value loaded when load=1
//   limit     in   WIDTH        upper bound; legal range is 0..limit
//   div       in   PRESCALE_W   step every div+1 enabled cycles (0 = every cycle)
//   count     out  WIDTH        current count (registered)
//   tc        out  1            terminal-count pulse (registered, 1 cycle)
// BEHAVIOUR
//   - One clock clk; reset rst asynchronous, active-high. While rst=1:
//     count=RESET_VAL, tc=0, prescaler pcnt=0; first update on first clk edge after release.
//   - Priority per edge: load > step > hold.
//   - load=1: count<=load_val (even if >limit, even with en=0); pcnt<=0; tc<=0.
//   - Prescaler: when en=1 and load=0: if pcnt==div then step=1, pcnt<=0;
//     else pcnt<=pcnt+1. en=0 freezes pcnt. div changed mid-run: compare uses new
//     value; if pcnt>div then step=1 and pcnt<=0 next enabled cycle (no long stall).
//   - Step up (up_dn=1):  count<limit -> count+1, tc<=0.
//     count>=limit -> boundary: wrap: count<=0; sat: count<=limit; tc<=1.
//   - Step down (up_dn=0): count>0 and count<=limit -> count-1, tc<=0.
//     count==0 -> boundary: wrap: count<=limit; sat: hold 0; tc<=1.
//     count>limit (runtime limit lowered) -> count<=limit, tc<=0 (clamp, no pulse).
//   - No step and no load: count holds, tc<=0 (tc is a single-cycle pulse per
//     boundary step; repeated saturated steps give one pulse per step).
//   - Latency: count/tc change on the edge where step/load is taken; visible
//     immediately after that edge. No combinational path input->output.
//   - limit=0: every step is a boundary step; count stays 0 (wrap or sat), tc=1 each step.
//   - up_dn, sat_mode, limit sampled each edge; changes take effect on next step.
//   - All arithmetic WIDTH bits unsigned; no carry out beyond WIDTH.
//   - rst asserted mid-operation: outputs return to reset values asynchronously.
// TESTING (WIDTH=4, PRESCALE_W=4, RESET_VAL=0 unless stated)
//   1 rst pulse, en=1,up,wrap,limit=15,div=0, 20 clks -> count 1..15,0..4; tc=1 only
//     on the cycle count shows 0 (16th edge).
//   2 limit=9, sat, up, div=0, 12 clks -> count 1..9 then holds 9; tc=1 on edges 10,11,12.
//   3 load=1 load_val=3, then down, wrap, limit=5, 5 clks -> 3,2,1,0,5; tc=1 with 5.
//   4 div=2, en=1, up -> count increments every 3rd edge; drop en for 4 clks mid-run
//     -> count and phase frozen, resume exactly where stopped.
//   5 count=12, lower limit to 7, down step -> count=7, tc=0; up step -> count=0
//     (wrap), tc=1.
//   6 assert rst asynchronously between edges at count=6 -> count=0, tc=0 before next
//     edge; load and en simultaneous -> load wins, pcnt cleared.

Source files
------------

// File: rtl/yavar_param_counter.sv
// ============================================================================
// Module   : yavar_param_counter
// Brief    : Up/down counter with runtime modulus, wrap/saturate mode,
//            synchronous load, enable prescaler and registered terminal count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module yavar_param_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4,
  parameter int RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] div,
  output logic [WIDTH-1:0]      count,
  output logic                  tc
);

  localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0]      count_q, count_d;
  logic                  tc_q, tc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  w_step;

  // A prescaler phase beyond a freshly lowered div fires at once instead of
  // running all the way round the prescaler range.
  always_comb begin
    count_d = count_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    w_step  = 1'b0;
    if (load) begin
      count_d = load_val;
      pcnt_d  = '0;
    end else if (en) begin
      if (pcnt_q >= div) begin
        w_step = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
      if (w_step) begin
        if (up_dn) begin
          if (count_q < limit) begin
            count_d = count_q + 1'b1;
          end else begin
            count_d = sat_mode ? limit : '0;
            tc_d    = 1'b1;
          end
        end else begin
          if (count_q > limit) begin
            count_d = limit;
          end else if (count_q == '0) begin
            count_d = sat_mode ? '0 : limit;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= c_RESET_VAL;
      tc_q    <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_yavar_param_counter.sv
// ============================================================================
// Module   : tb_yavar_param_counter
// Brief    : Scoreboard bench for yavar_param_counter (WIDTH=4, PRESCALE_W=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_yavar_param_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0, limit = 4'd15, div = '0;
  logic [3:0] count;
  logic       tc;

  int checks   = 0;
  int failures = 0;

  logic [4:0] sb[$];

  // reference state: plain integers following the counting rules
  int m_count = 0;
  int m_pcnt  = 0;
  int m_tc    = 0;

  yavar_param_counter #(.WIDTH(4), .PRESCALE_W(4), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .limit(limit), .div(div),
    .count(count), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input bit r, e, u, s, l,
                                     input int lv, lim, d);
    bit stepping;
    if (r) begin
      m_count = 0; m_pcnt = 0; m_tc = 0;
    end else if (l) begin
      m_count = lv; m_pcnt = 0; m_tc = 0;
    end else if (!e) begin
      m_tc = 0;
    end else begin
      stepping = (m_pcnt >= d);
      m_pcnt   = stepping ? 0 : m_pcnt + 1;
      m_tc     = 0;
      if (stepping && u) begin
        if (m_count < lim) m_count = m_count + 1;
        else begin m_count = s ? lim : 0; m_tc = 1; end
      end else if (stepping) begin
        if (m_count > lim) m_count = lim;
        else if (m_count == 0) begin m_count = s ? 0 : lim; m_tc = 1; end
        else m_count = m_count - 1;
      end
    end
  endfunction

  // Inputs change 2 time units after a rising edge and are held for one edge.
  task automatic drive(input bit r, e, u, s, l, input int lv, lim, d);
    rst = r; en = e; up_dn = u; sat_mode = s; load = l;
    load_val = 4'(lv); limit = 4'(lim); div = 4'(d);
    @(posedge clk);
    model_edge(r, e, u, s, l, lv, lim, d);
    sb.push_back({4'(m_count), m_tc[0]});
    #2;
  endtask

  // Reset pulse placed entirely between two edges; with en/load low the next
  // edge must leave the counter at its reset value.
  task automatic async_reset();
    @(negedge clk);
    #1;
    en = 1'b0; load = 1'b0; rst = 1'b1;
    #2;
    rst = 1'b0;
    m_count = 0; m_pcnt = 0; m_tc = 0;
  endtask

  always @(negedge clk) begin
    logic [4:0] exp_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if ({count, tc} !== exp_v) begin
        failures++;
        $display("FAIL cnt_tc t=%0t count=%0d tc=%0b expected count=%0d tc=%0b",
                 $time, count, tc, exp_v[4:1], exp_v[0]);
      end
    end
  end

  initial begin
    int lim_r;
    // reset held over two edges
    drive(1, 1, 1, 0, 0, 0, 15, 0);
    drive(1, 1, 1, 0, 0, 0, 15, 0);
    // 1: wrap up through full range
    for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0, 0, 15, 0);
    // 2: saturate at 9
    drive(0, 0, 1, 1, 1, 0, 9, 0);
    for (int i = 0; i < 12; i++) drive(0, 1, 1, 1, 0, 0, 9, 0);
    // 3: load 3, count down and wrap to limit 5
    drive(0, 0, 0, 0, 1, 3, 5, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 5, 0);
    // 4: prescaler div=2, freeze with en=0 mid-run
    drive(0, 0, 1, 0, 1, 0, 15, 2);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, 0, 0, 15, 2);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 15, 2);
    for (int i = 0; i < 7; i++) drive(0, 1, 1, 0, 0, 0, 15, 2);
    // div lowered below current phase
    drive(0, 1, 1, 0, 0, 0, 15, 3);
    drive(0, 1, 1, 0, 0, 0, 15, 3);
    drive(0, 1, 1, 0, 0, 0, 15, 0);
    // 5: limit lowered under count: clamp down, then wrap up
    drive(0, 0, 0, 0, 1, 12, 15, 0);
    drive(0, 1, 0, 0, 0, 0, 7, 0);
    drive(0, 1, 1, 0, 0, 0, 7, 0);
    // limit=0 in both modes
    for (int i = 0; i < 3; i++) drive(0, 1, i[0], i[1], 0, 0, 0, 0);
    // 6: async reset at count 6, then load+en together with nonzero phase
    drive(0, 0, 1, 0, 1, 5, 15, 0);
    drive(0, 1, 1, 0, 0, 0, 15, 0);
    async_reset();
    drive(0, 0, 1, 0, 0, 0, 15, 0);
    drive(0, 1, 1, 0, 0, 0, 15, 3);
    drive(0, 1, 1, 0, 0, 0, 15, 3);
    drive(0, 1, 1, 0, 1, 10, 15, 3);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 0, 15, 3);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) async_reset();
      lim_r = ($urandom_range(3) == 0) ? $urandom_range(2) : $urandom_range(15);
      drive(0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(1),
            $urandom_range(15) == 0, $urandom_range(15), lim_r, $urandom_range(3));
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
